mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
Debug/load controller that sequences the pipelined MIPS core (MIPS2) from a byte-wide serial command stream, typically UART RX.
- Loads program memory through the core's WrPM/WrDataPM port.
- Holds the pipeline in reset during loading.
- Provides run, single-step and pause control through a pipeline clock-enable.
- Sits between the UART receiver and the MIPS2 top level.

Parameters:
PM_DEPTH, 32, program memory depth in 32-bit words; words beyond this are consumed but not written
CNT_W, 16, width of the load word counter and the cycle counter
TIMEOUT_CYCLES, 1000000, idle-byte timeout during LOAD; used only with MIPS_DBG_TIMEOUT_EN

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
I_RX_DATA  in  8  received byte
I_RX_VALID  in  1  one-cycle strobe, I_RX_DATA valid
I_MIPS_HALT  in  1  core reports HALT instruction retired (level)
O_MIPS_RESET  out  1  active-high reset to MIPS2 (pipeline and PM write pointer)
O_MIPS_EN  out  1  pipeline clock-enable
O_MIPS_WrPM  out  1  program memory write strobe, one cycle per word
O_MIPS_WrDataPM  out  32  word to write
O_STATE  out  3  current FSM state encoding
O_WORD_CNT  out  CNT_W  words received in the current load
O_CYCLE_CNT  out  CNT_W  enabled cycles since the last load or clear (saturating)
O_ERR  out  1  sticky error: unknown command or timeout; cleared by 'C'

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE; O_MIPS_RESET=1, O_MIPS_EN=0, O_MIPS_WrPM=0, O_MIPS_WrDataPM=0.
  - All counters 0; O_ERR=0; byte-assembly registers cleared.
- FSM states and encodings: IDLE=0, LEN=1, LOAD=2, RUN=3, STEP=4, DONE=5.
- IDLE (O_MIPS_EN=0; O_MIPS_RESET keeps its last value). Accepts these commands on I_RX_VALID:
  - 0x4C 'L' -> LEN. O_MIPS_RESET=1 and O_WORD_CNT=0 take effect in the same edge.
  - 0x52 'R' -> RUN. O_MIPS_RESET=0.
  - 0x53 'S' -> STEP. O_MIPS_RESET=0.
  - 0x43 'C' -> stay IDLE. Assert O_MIPS_RESET for exactly one cycle, then release. Clear O_CYCLE_CNT and O_ERR.
  - Any other byte -> O_ERR=1, stay IDLE.
- LEN:
  - Collects 2 bytes, little-endian, into the word count N.
  - N=0 -> IDLE, no writes.
  - Otherwise -> LOAD.
- LOAD:
  - Assembles bytes little-endian (first byte = bits[7:0]).
  - On the 4th byte of a word: the next cycle drives O_MIPS_WrPM=1 with O_MIPS_WrDataPM=word for exactly one cycle, and O_WORD_CNT increments.
  - Words with index >= PM_DEPTH increment O_WORD_CNT but suppress O_MIPS_WrPM.
  - After word N: -> IDLE, with O_MIPS_RESET still 1.
  - A byte arriving in the same cycle as the WrPM pulse is accepted normally.
- RUN:
  - O_MIPS_EN=1 every cycle; O_CYCLE_CNT increments per enabled cycle and saturates at all-ones.
  - I_MIPS_HALT=1 -> DONE, O_MIPS_EN=0 from the next cycle.
  - Received 0x50 'P' -> IDLE (pause; state preserved, no reset).
  - Other bytes are ignored.
- STEP:
  - O_MIPS_EN=1 for exactly one cycle, then -> IDLE, or -> DONE if I_MIPS_HALT=1.
  - A byte arriving during STEP is ignored.
- DONE:
  - O_MIPS_EN=0.
  - 'C' -> IDLE with the one-cycle reset pulse.
  - 'L' -> LEN.
  - Other bytes are ignored.
- Halt at entry: 'R' or 'S' issued while I_MIPS_HALT=1 -> DONE immediately, with no enabled cycle.
- Timing: all outputs are registered; command-to-effect latency is 1 cycle.
- Reset mid-LOAD: aborts the load, discards any partial word, no write issued.

Optional Feature:
MIPS_DBG_TIMEOUT_EN:
- Defined: a down-counter reloads to TIMEOUT_CYCLES on every I_RX_VALID while in LEN or LOAD. Reaching 0 forces IDLE, sets O_ERR=1, discards any partial word, and issues no write.
- Undefined: no timeout logic; LEN/LOAD wait indefinitely.

Test Plan:
- Load: reset, then bytes 4C 02 00 78 56 34 12 EF BE AD DE -> two WrPM pulses with data 0x12345678 then 0xDEADBEEF; O_WORD_CNT=2; O_MIPS_RESET=1 throughout; final state IDLE.
- Run to halt: after the load, send 'R'; raise I_MIPS_HALT after 10 cycles -> O_MIPS_EN high exactly 10 cycles, O_CYCLE_CNT=10, state DONE.
- Step and error: send 'S' three times with gaps -> exactly 3 single-cycle O_MIPS_EN pulses, O_CYCLE_CNT=3. Send 0x99 -> O_ERR=1; then 'C' -> O_ERR=0, O_CYCLE_CNT=0, one-cycle O_MIPS_RESET pulse.
- Depth overflow and zero length: PM_DEPTH=4, load N=6 -> O_WORD_CNT=6 but only 4 WrPM pulses. 'L' 00 00 -> IDLE, zero writes.
- Pause and resume: 'R', then 'P' after 5 cycles, then 'R' -> O_MIPS_RESET stays 0; O_CYCLE_CNT continues from 5.
- Reset abort (plus timeout, with MIPS_DBG_TIMEOUT_EN and TIMEOUT_CYCLES=20): assert RESET after 2 bytes of a load word -> no WrPM, all outputs at reset values. With the macro: stop bytes mid-word for 20 cycles -> state IDLE, O_ERR=1, no write.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
// Byte-command debug/load sequencer for the MIPS2 core: program load, run, step, pause.
// Optional idle-byte timeout in LEN/LOAD is enabled by defining MIPS_DBG_TIMEOUT_EN.
module mips_debug_ctrl #(
  parameter int unsigned PM_DEPTH       = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       I_RX_DATA,
  input  logic             I_RX_VALID,
  input  logic             I_MIPS_HALT,
  output logic             O_MIPS_RESET,
  output logic             O_MIPS_EN,
  output logic             O_MIPS_WrPM,
  output logic [31:0]      O_MIPS_WrDataPM,
  output logic [2:0]       O_STATE,
  output logic [CNT_W-1:0] O_WORD_CNT,
  output logic [CNT_W-1:0] O_CYCLE_CNT,
  output logic             O_ERR
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLen  = 3'd1,
    StLoad = 3'd2,
    StRun  = 3'd3,
    StStep = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam logic [7:0] CmdLoad  = 8'h4C;
  localparam logic [7:0] CmdRun   = 8'h52;
  localparam logic [7:0] CmdStep  = 8'h53;
  localparam logic [7:0] CmdClear = 8'h43;
  localparam logic [7:0] CmdPause = 8'h50;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic             mips_rst_q, mips_rst_d;
  logic             en_q, en_d;
  logic             wrpm_q, wrpm_d;
  logic [31:0]      wrdata_q, wrdata_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             err_q, err_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      asm_q, asm_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      load_idx_q, load_idx_d;
  logic             rst_pulse_q, rst_pulse_d;
  logic [15:0]      len_full;

`ifdef MIPS_DBG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoReload = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoOne    = TmoW'(1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  assign len_full = {I_RX_DATA, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    mips_rst_d  = mips_rst_q;
    en_d        = 1'b0;
    wrpm_d      = 1'b0;
    wrdata_d    = wrdata_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    len_d       = len_q;
    load_idx_d  = load_idx_q;
    rst_pulse_d = 1'b0;

    // The clear command holds the core in reset for a single cycle only.
    if (rst_pulse_q) mips_rst_d = 1'b0;
    if (en_q && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + CntOne;

    unique case (state_q)
      StIdle, StDone: begin
        if (I_RX_VALID) begin
          if (I_RX_DATA == CmdLoad) begin
            state_d     = StLen;
            mips_rst_d  = 1'b1;
            word_cnt_d  = '0;
            cycle_cnt_d = '0;
            byte_idx_d  = '0;
            load_idx_d  = '0;
          end else if (I_RX_DATA == CmdClear) begin
            state_d     = StIdle;
            mips_rst_d  = 1'b1;
            rst_pulse_d = 1'b1;
            cycle_cnt_d = '0;
            err_d       = 1'b0;
          end else if (state_q == StIdle) begin
            if ((I_RX_DATA == CmdRun) || (I_RX_DATA == CmdStep)) begin
              mips_rst_d = 1'b0;
              if (I_MIPS_HALT) begin
                state_d = StDone;
              end else begin
                state_d = (I_RX_DATA == CmdRun) ? StRun : StStep;
                en_d    = 1'b1;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      StLen: begin
        if (I_RX_VALID) begin
          if (byte_idx_q == 2'd0) begin
            len_d[7:0] = I_RX_DATA;
            byte_idx_d = 2'd1;
          end else begin
            byte_idx_d = 2'd0;
            len_d      = len_full;
            state_d    = (len_full == 16'd0) ? StIdle : StLoad;
          end
        end
      end
      StLoad: begin
        if (I_RX_VALID) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = I_RX_DATA;
            2'd1: asm_d[15:8]  = I_RX_DATA;
            2'd2: asm_d[23:16] = I_RX_DATA;
            default: begin
              wrdata_d   = {I_RX_DATA, asm_q};
              wrpm_d     = (32'(load_idx_q) < PM_DEPTH);
              word_cnt_d = word_cnt_q + CntOne;
              load_idx_d = load_idx_q + 16'd1;
              if ((load_idx_q + 16'd1) == len_q) state_d = StIdle;
            end
          endcase
        end
      end
      StRun: begin
        if (I_MIPS_HALT) begin
          state_d = StDone;
        end else if (I_RX_VALID && (I_RX_DATA == CmdPause)) begin
          state_d = StIdle;
        end else begin
          en_d = 1'b1;
        end
      end
      StStep: begin
        state_d = I_MIPS_HALT ? StDone : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef MIPS_DBG_TIMEOUT_EN
    tmo_d = TmoReload;
    if ((state_q == StLen) || (state_q == StLoad)) begin
      if (I_RX_VALID) begin
        tmo_d = TmoReload;
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - TmoOne;
      end else begin
        state_d    = StIdle;
        err_d      = 1'b1;
        byte_idx_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      mips_rst_q  <= 1'b1;
      en_q        <= 1'b0;
      wrpm_q      <= 1'b0;
      wrdata_q    <= '0;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      len_q       <= '0;
      load_idx_q  <= '0;
      rst_pulse_q <= 1'b0;
`ifdef MIPS_DBG_TIMEOUT_EN
      tmo_q       <= TmoReload;
`endif
    end else begin
      state_q     <= state_d;
      mips_rst_q  <= mips_rst_d;
      en_q        <= en_d;
      wrpm_q      <= wrpm_d;
      wrdata_q    <= wrdata_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      len_q       <= len_d;
      load_idx_q  <= load_idx_d;
      rst_pulse_q <= rst_pulse_d;
`ifdef MIPS_DBG_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign O_STATE         = state_q;
  assign O_MIPS_RESET    = mips_rst_q;
  assign O_MIPS_EN       = en_q;
  assign O_MIPS_WrPM     = wrpm_q;
  assign O_MIPS_WrDataPM = wrdata_q;
  assign O_WORD_CNT      = word_cnt_q;
  assign O_CYCLE_CNT     = cycle_cnt_q;
  assign O_ERR           = err_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Randomized self-checking bench for mips_debug_ctrl against a command-level reference model.
module tb_mips_debug_ctrl;

  localparam int unsigned PmDepth = 4;
  localparam int unsigned CntW    = 16;
  localparam int unsigned TmoCyc  = 20;

  localparam int StIdle = 0;
  localparam int StLen  = 1;
  localparam int StLoad = 2;
  localparam int StDone = 5;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic [7:0]      I_RX_DATA = 8'h00;
  logic            I_RX_VALID = 1'b0;
  logic            I_MIPS_HALT = 1'b0;
  logic            O_MIPS_RESET;
  logic            O_MIPS_EN;
  logic            O_MIPS_WrPM;
  logic [31:0]     O_MIPS_WrDataPM;
  logic [2:0]      O_STATE;
  logic [CntW-1:0] O_WORD_CNT;
  logic [CntW-1:0] O_CYCLE_CNT;
  logic            O_ERR;

  mips_debug_ctrl #(
    .PM_DEPTH      (PmDepth),
    .CNT_W         (CntW),
    .TIMEOUT_CYCLES(TmoCyc)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .I_RX_DATA      (I_RX_DATA),
    .I_RX_VALID     (I_RX_VALID),
    .I_MIPS_HALT    (I_MIPS_HALT),
    .O_MIPS_RESET   (O_MIPS_RESET),
    .O_MIPS_EN      (O_MIPS_EN),
    .O_MIPS_WrPM    (O_MIPS_WrPM),
    .O_MIPS_WrDataPM(O_MIPS_WrDataPM),
    .O_STATE        (O_STATE),
    .O_WORD_CNT     (O_WORD_CNT),
    .O_CYCLE_CNT    (O_CYCLE_CNT),
    .O_ERR          (O_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Observed activity, sampled mid-cycle.
  logic [31:0] wr_q[$];
  int en_cycles  = 0;
  int rst_cycles = 0;
  int rst_viol   = 0;

  // Reference model state.
  logic [31:0] ld_words[$];
  int cyc_model = 0;

  always @(negedge CLK) begin
    if (O_MIPS_WrPM) wr_q.push_back(O_MIPS_WrDataPM);
    if (O_MIPS_EN) en_cycles++;
    if (O_MIPS_RESET) rst_cycles++;
    if (RESET && ((O_STATE == 3'(StLen)) || (O_STATE == 3'(StLoad))) && !O_MIPS_RESET) rst_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    I_RX_DATA  = b;
    I_RX_VALID = 1'b1;
    tick(1);
    I_RX_VALID = 1'b0;
    tick(gap);
  endtask

  // Loads ld_words; the model expects only the first PmDepth words to be written.
  task automatic load_words(input string tag);
    int n;
    int n_exp;
    n = ld_words.size();
    n_exp = (n < int'(PmDepth)) ? n : int'(PmDepth);
    wr_q.delete();
    send_byte(8'h4C, $urandom_range(0, 2));
    send_byte(8'(n), $urandom_range(0, 2));
    send_byte(8'(n >> 8), $urandom_range(0, 2));
    foreach (ld_words[i]) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(8'(ld_words[i] >> (8 * b)), $urandom_range(0, 2));
      end
    end
    tick(2);
    cyc_model = 0;
    check_eq({tag, " nwrites"}, 32'(wr_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      check_eq($sformatf("%s wdata%0d", tag, i), wr_q[i], ld_words[i]);
    end
    check_eq({tag, " word_cnt"}, 32'(O_WORD_CNT), 32'(n));
    check_eq({tag, " state"}, 32'(O_STATE), 32'(StIdle));
    check_eq({tag, " mips_reset"}, 32'(O_MIPS_RESET), 32'd1);
    check_eq({tag, " cycle_cnt"}, 32'(O_CYCLE_CNT), 32'(cyc_model));
  endtask

  // Issues cmd, keeps the core enabled for k cycles, then ends with halt or 'P'.
  task automatic run_k(input logic [7:0] cmd, input int k, input bit halt_end);
    I_RX_DATA  = cmd;
    I_RX_VALID = 1'b1;
    tick(1);
    I_RX_VALID = 1'b0;
    tick(k - 1);
    if (halt_end) begin
      I_MIPS_HALT = 1'b1;
    end else begin
      I_RX_DATA  = 8'h50;
      I_RX_VALID = 1'b1;
    end
    tick(1);
    I_RX_VALID = 1'b0;
    tick(2);
    cyc_model += k;
  endtask

  task automatic clear_cmd(input string tag);
    int r0;
    r0 = rst_cycles;
    send_byte(8'h43, 3);
    cyc_model = 0;
    check_eq({tag, " rst_pulse"}, 32'(rst_cycles - r0), 32'd1);
    check_eq({tag, " state"}, 32'(O_STATE), 32'(StIdle));
    check_eq({tag, " err"}, 32'(O_ERR), 32'd0);
    check_eq({tag, " cycle_cnt"}, 32'(O_CYCLE_CNT), 32'(cyc_model));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " state"}, 32'(O_STATE), 32'(StIdle));
    check_eq({tag, " mips_reset"}, 32'(O_MIPS_RESET), 32'd1);
    check_eq({tag, " en"}, 32'(O_MIPS_EN), 32'd0);
    check_eq({tag, " wrpm"}, 32'(O_MIPS_WrPM), 32'd0);
    check_eq({tag, " wrdata"}, O_MIPS_WrDataPM, 32'd0);
    check_eq({tag, " word_cnt"}, 32'(O_WORD_CNT), 32'd0);
    check_eq({tag, " cycle_cnt"}, 32'(O_CYCLE_CNT), 32'd0);
    check_eq({tag, " err"}, 32'(O_ERR), 32'd0);
  endtask

  initial begin
    int e0;
    int r0;
    int k;
    int m;
    logic [7:0] bad;

    tick(3);
    check_reset_vals("reset");
    RESET = 1'b1;
    tick(2);

    ld_words = '{32'h12345678, 32'hDEADBEEF};
    load_words("load_fixed");

    // Run until halt after 10 enabled cycles.
    e0 = en_cycles;
    run_k(8'h52, 10, 1'b1);
    I_MIPS_HALT = 1'b0;
    check_eq("run en_cycles", 32'(en_cycles - e0), 32'd10);
    check_eq("run cycle_cnt", 32'(O_CYCLE_CNT), 32'(cyc_model));
    check_eq("run state", 32'(O_STATE), 32'(StDone));
    check_eq("run en_off", 32'(O_MIPS_EN), 32'd0);
    send_byte(8'h52, 2);
    check_eq("done ignores R", 32'(O_STATE), 32'(StDone));
    clear_cmd("clear_done");

    // Single steps.
    e0 = en_cycles;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53, $urandom_range(2, 4));
      cyc_model++;
    end
    check_eq("step en_cycles", 32'(en_cycles - e0), 32'd3);
    check_eq("step cycle_cnt", 32'(O_CYCLE_CNT), 32'(cyc_model));
    check_eq("step state", 32'(O_STATE), 32'(StIdle));

    // Unknown command sets the sticky error.
    do bad = 8'($urandom_range(0, 255));
    while (bad == 8'h4C || bad == 8'h52 || bad == 8'h53 || bad == 8'h43);
    send_byte(bad, 2);
    check_eq("err set", 32'(O_ERR), 32'd1);
    check_eq("err state", 32'(O_STATE), 32'(StIdle));
    clear_cmd("clear_err");

    // Random loads, some exceeding program memory depth.
    for (int it = 0; it < 4; it++) begin
      ld_words.delete();
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) ld_words.push_back($urandom());
      load_words($sformatf("load_rand%0d", it));
    end

    ld_words.delete();
    load_words("load_zero");

    // Pause and resume.
    m = $urandom_range(3, 8);
    e0 = en_cycles;
    run_k(8'h52, m, 1'b0);
    r0 = rst_cycles;
    check_eq("pause state", 32'(O_STATE), 32'(StIdle));
    check_eq("pause cycle_cnt", 32'(O_CYCLE_CNT), 32'(cyc_model));
    k = $urandom_range(2, 8);
    run_k(8'h52, k, 1'b1);
    I_MIPS_HALT = 1'b0;
    check_eq("resume en_cycles", 32'(en_cycles - e0), 32'(m + k));
    check_eq("resume cycle_cnt", 32'(O_CYCLE_CNT), 32'(cyc_model));
    check_eq("resume no_reset", 32'(rst_cycles - r0), 32'd0);
    check_eq("resume state", 32'(O_STATE), 32'(StDone));
    clear_cmd("clear_resume");

    // Halt already asserted when run/step is issued.
    I_MIPS_HALT = 1'b1;
    e0 = en_cycles;
    send_byte(8'h53, 2);
    check_eq("halt_entry S state", 32'(O_STATE), 32'(StDone));
    send_byte(8'h43, 2);
    send_byte(8'h52, 2);
    check_eq("halt_entry R state", 32'(O_STATE), 32'(StDone));
    check_eq("halt_entry en_cycles", 32'(en_cycles - e0), 32'd0);
    I_MIPS_HALT = 1'b0;
    clear_cmd("clear_halt");

`ifdef MIPS_DBG_TIMEOUT_EN
    wr_q.delete();
    send_byte(8'h4C, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    tick(int'(TmoCyc) + 10);
    check_eq("timeout state", 32'(O_STATE), 32'(StIdle));
    check_eq("timeout err", 32'(O_ERR), 32'd1);
    check_eq("timeout nwrites", 32'(wr_q.size()), 32'd0);
    clear_cmd("clear_timeout");
`endif

    // Reset in the middle of a word aborts the load.
    wr_q.delete();
    send_byte(8'h4C, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    RESET = 1'b0;
    tick(2);
    check_reset_vals("reset_abort");
    check_eq("reset_abort nwrites", 32'(wr_q.size()), 32'd0);
    RESET = 1'b1;
    tick(3);
    check_eq("reset_abort after nwrites", 32'(wr_q.size()), 32'd0);
    check_eq("reset_abort after state", 32'(O_STATE), 32'(StIdle));

    check_eq("load holds reset", 32'(rst_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
